// File: rtl/bounce_pkg.sv
// Shared types and constants for the switch-bounce emulator.
package bounce_pkg;

  typedef enum logic [1:0] {
    STABLE = 2'd0,
    BOUNCE = 2'd1,
    SETTLE = 2'd2
  } state_t;

  localparam logic [15:0] LFSR_TAPS    = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

  // Right-shifting Galois step: feedback bit is the LSB shifted out.
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Galois LFSR; a zero seed is replaced so it can never lock up.
module lfsr16
  import bounce_pkg::*;
#(
  parameter logic [15:0] SEED = DEFAULT_SEED
) (
  input  logic        clock,
  input  logic        reset,
  output logic [15:0] q
);

  localparam logic [15:0] INIT = (SEED == 16'd0) ? 16'h0001 : SEED;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) q <= INIT;
    else       q <= lfsr_next(q);
  end

endmodule

// File: rtl/bounce_generator.sv
// Switch-bounce emulator: turns a clean press level into a bouncing raw contact
// level with LFSR-driven toggle spacing, then reports settle with a done pulse.
module bounce_generator
  import bounce_pkg::*;
#(
  parameter int          CNT_W      = 16,
  parameter int          BOUNCE_LEN = 1000,
  parameter int          MIN_GAP    = 4,
  parameter int          GAP_BITS   = 3,
  parameter logic [15:0] LFSR_SEED  = DEFAULT_SEED
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       press,
  input  logic       bounce_en,
  output logic       raw,
  output logic       busy,
  output logic       done,
  output logic [7:0] edge_count
);

  localparam int               GAP_W    = $clog2(MIN_GAP + (1 << GAP_BITS) + 1);
  localparam logic [CNT_W-1:0] WIN_LOAD = CNT_W'(BOUNCE_LEN - 1);

  state_t           state;
  logic             target;
  logic [CNT_W-1:0] win;
  logic [GAP_W-1:0] gap;
  logic [GAP_W-1:0] gap_load;
  logic [7:0]       ec_inc;
  logic [15:0]      lfsr;
  logic             unused_lfsr_bits;

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clock (clock),
    .reset (reset),
    .q     (lfsr)
  );

  assign gap_load         = GAP_W'(MIN_GAP) + GAP_W'(lfsr[GAP_BITS-1:0]);
  assign ec_inc           = (edge_count == 8'hFF) ? 8'hFF : edge_count + 8'd1;
  assign unused_lfsr_bits = ^lfsr;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= STABLE;
      target     <= 1'b0;
      raw        <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      edge_count <= 8'd0;
      win        <= '0;
      gap        <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        STABLE: begin
          if (press != target) begin
            target     <= press;
            edge_count <= 8'd1;
            if (bounce_en) begin
              raw   <= ~raw;
              win   <= WIN_LOAD;
              gap   <= gap_load;
              busy  <= 1'b1;
              state <= BOUNCE;
            end else begin
              raw   <= press;
              state <= SETTLE;
            end
          end
        end
        BOUNCE: begin
          if (win == '0) begin
            raw   <= target;
            busy  <= 1'b0;
            state <= SETTLE;
            if (raw != target) edge_count <= ec_inc;
          end else begin
            win <= win - CNT_W'(1);
            // gap counts cycles left until the next toggle; it fires as it expires
            if (gap == GAP_W'(1)) begin
              raw        <= ~raw;
              edge_count <= ec_inc;
              gap        <= gap_load;
            end else begin
              gap <= gap - GAP_W'(1);
            end
          end
        end
        SETTLE: begin
          done  <= 1'b1;
          state <= STABLE;
        end
        default: state <= STABLE;
      endcase
    end
  end

endmodule
